// File: rtl/ln_tile_packer.sv
// ln_tile_packer: gathers a row-major element stream into one flattened
// SEQ_LEN x EMB_DIM tile, pulses ln_start once the tile is complete, then
// holds the tile and blocks the stream until the normaliser reports done.
module ln_tile_packer #(
    parameter int DATA_WIDTH = 16,
    parameter int SEQ_LEN    = 16,
    parameter int EMB_DIM    = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    input  logic [DATA_WIDTH-1:0]                 in_data,
    input  logic                                  in_last,
    output logic                                  in_ready,
    output logic [DATA_WIDTH*SEQ_LEN*EMB_DIM-1:0] x_out,
    output logic                                  ln_start,
    input  logic                                  ln_done,
    output logic                                  busy,
    output logic                                  frame_err,
    output logic [15:0]                           tile_cnt
);

    localparam int N  = SEQ_LEN * EMB_DIM;
    localparam int KW = $clog2(N);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t          state_reg;
    logic [KW-1:0]   k_reg;
    logic            ln_start_reg;
    logic            busy_reg;
    logic            frame_err_reg;
    logic [15:0]     tile_cnt_reg;

    logic            accept;
    logic            last_slot;

    // Ready only while filling; forced low during reset so no beat is lost.
    assign in_ready  = (state_reg == S_FILL) && !rst;
    assign accept    = in_valid && in_ready;
    assign last_slot = (k_reg == KW'(N - 1));

    assign ln_start  = ln_start_reg;
    assign busy      = busy_reg;
    assign frame_err = frame_err_reg;
    assign tile_cnt  = tile_cnt_reg;

    // One register per tile slot; a slot only changes on an accepted beat
    // aimed at it, so the tile is frozen outside S_FILL.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slot
            logic [DATA_WIDTH-1:0] slot_reg;

            // Capture the incoming element when the write index points here.
            always_ff @(posedge clk) begin
                if (rst) begin
                    slot_reg <= '0;
                end else if (accept && (k_reg == KW'(gi))) begin
                    slot_reg <= in_data;
                end
            end

            assign x_out[gi*DATA_WIDTH +: DATA_WIDTH] = slot_reg;
        end
    endgenerate

    // Control FSM: fill index, tile issue, done handshake and framing checks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_FILL;
            k_reg         <= '0;
            ln_start_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            frame_err_reg <= 1'b0;
            tile_cnt_reg  <= '0;
        end else begin
            ln_start_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            case (state_reg)
                S_FILL: begin
                    if (accept) begin
                        if (last_slot) begin
                            // Tile complete: issue it even if in_last was missing.
                            k_reg         <= '0;
                            state_reg     <= S_START;
                            ln_start_reg  <= 1'b1;
                            tile_cnt_reg  <= tile_cnt_reg + 16'd1;
                            frame_err_reg <= !in_last;
                        end else if (in_last) begin
                            // Early last: drop the partial tile and restart at slot 0.
                            k_reg         <= '0;
                            frame_err_reg <= 1'b1;
                        end else begin
                            k_reg <= k_reg + KW'(1);
                        end
                    end
                end
                S_START: begin
                    busy_reg  <= 1'b1;
                    state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    if (ln_done) begin
                        busy_reg  <= 1'b0;
                        state_reg <= S_FILL;
                    end
                end
                default: begin
                    state_reg <= S_FILL;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ln_tile_packer.sv
// Testbench for ln_tile_packer with a 2x4 tile: a cycle table of directed
// vectors, randomized gapped tiles against a tile scoreboard, and reset cases.
module tb_ln_tile_packer;

    localparam int DW = 16;
    localparam int SL = 2;
    localparam int ED = 4;
    localparam int N  = SL * ED;
    localparam int XW = DW * N;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          in_ready;
    logic [XW-1:0] x_out;
    logic          ln_start;
    logic          ln_done;
    logic          busy;
    logic          frame_err;
    logic [15:0]   tile_cnt;

    ln_tile_packer #(
        .DATA_WIDTH (DW),
        .SEQ_LEN    (SL),
        .EMB_DIM    (ED)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .x_out     (x_out),
        .ln_start  (ln_start),
        .ln_done   (ln_done),
        .busy      (busy),
        .frame_err (frame_err),
        .tile_cnt  (tile_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          l;
        logic          done;
        logic          e_rdy;
        logic          e_start;
        logic          e_ferr;
        logic          e_busy;
        logic [15:0]   e_cnt;
        logic          cx;
        logic [XW-1:0] e_x;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [XW-1:0] act, input logic [XW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Tile whose slot i holds base+i.
    function automatic logic [XW-1:0] ramp(input logic [DW-1:0] base);
        logic [XW-1:0] t;
        t = '0;
        for (int i = 0; i < N; i++) t[i*DW +: DW] = base + DW'(i);
        return t;
    endfunction

    function automatic void add(input logic v, input logic [DW-1:0] d, input logic l,
                                input logic done, input logic rdy, input logic st,
                                input logic fe, input logic bz, input logic [15:0] cnt,
                                input logic cx, input logic [XW-1:0] x);
        vec_t e;
        e.v = v; e.d = d; e.l = l; e.done = done;
        e.e_rdy = rdy; e.e_start = st; e.e_ferr = fe; e.e_busy = bz;
        e.e_cnt = cnt; e.cx = cx; e.e_x = x;
        tbl.push_back(e);
    endfunction

    // Drive one cycle of inputs, then settle just after the rising edge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic l, input logic done);
        in_valid = v; in_data = d; in_last = l; ln_done = done;
        @(posedge clk);
        #1;
    endtask

    // Back-to-back tile base..base+7 with in_last on the final beat.
    task automatic send_tile(input logic [DW-1:0] base);
        for (int i = 0; i < N; i++) begin
            step(1'b1, base + DW'(i), (i == N - 1), 1'b0);
            if (i < N - 1) chk($sformatf("early_start_b%0d", i), ln_start, 1'b0);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1'b0);
        chk({tag, "_x_out"}, x_out, '0);
        chk({tag, "_ln_start"}, ln_start, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_frame_err"}, frame_err, 1'b0);
        chk({tag, "_tile_cnt"}, tile_cnt, 16'd0);
    endtask

    initial begin
        logic [XW-1:0] t1, t10, t30, exp_tile;
        logic [15:0]   cnt0;
        logic          acc;
        int            beat, budget;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; ln_done = 1'b0;

        // ---- reset state ----
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);
        chk_reset_vals("reset");
        rst = 1'b0;
        #1;
        chk("ready_after_reset", in_ready, 1'b1);

        // ---- directed cycle table ----
        t1  = ramp(16'h0001);
        t10 = ramp(16'h0010);
        t30 = ramp(16'h0030);
        // tile 1: 0x0001..0x0008, last on beat 8
        for (int i = 0; i < N; i++)
            add(1, DW'(i + 1), (i == N - 1), 0, (i < N - 1), (i == N - 1), 0, 0,
                (i == N - 1) ? 16'd1 : 16'd0, (i == N - 1), t1);
        // stream pushes 0xFFFF while held for 20 cycles with no done
        for (int i = 0; i < 20; i++) add(1, 16'hFFFF, 0, 0, 0, 0, 0, 1, 16'd1, 1, t1);
        add(0, '0, 0, 1, 1, 0, 0, 0, 16'd1, 1, t1);   // done reopens stream
        add(0, '0, 0, 1, 1, 0, 0, 0, 16'd1, 1, t1);   // done ignored in fill
        // early last on beat 3
        add(1, 16'h0020, 0, 0, 1, 0, 0, 0, 16'd1, 0, '0);
        add(1, 16'h0021, 0, 0, 1, 0, 0, 0, 16'd1, 0, '0);
        add(1, 16'h0022, 1, 0, 1, 0, 1, 0, 16'd1, 0, '0);
        for (int i = 0; i < N; i++)
            add(1, DW'(16'h0010 + i), (i == N - 1), 0, (i < N - 1), (i == N - 1), 0, 0,
                (i == N - 1) ? 16'd2 : 16'd1, (i == N - 1), t10);
        add(0, '0, 0, 0, 0, 0, 0, 1, 16'd2, 1, t10);
        add(0, '0, 0, 1, 1, 0, 0, 0, 16'd2, 1, t10);
        // missing last: frame_err coincides with ln_start
        for (int i = 0; i < N; i++)
            add(1, DW'(16'h0030 + i), 0, 0, (i < N - 1), (i == N - 1), (i == N - 1), 0,
                (i == N - 1) ? 16'd3 : 16'd2, (i == N - 1), t30);
        add(0, '0, 0, 0, 0, 0, 0, 1, 16'd3, 1, t30);
        add(0, '0, 0, 1, 1, 0, 0, 0, 16'd3, 1, t30);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].done);
            chk($sformatf("v%0d_in_ready", i), in_ready, tbl[i].e_rdy);
            chk($sformatf("v%0d_ln_start", i), ln_start, tbl[i].e_start);
            chk($sformatf("v%0d_frame_err", i), frame_err, tbl[i].e_ferr);
            chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("v%0d_tile_cnt", i), tile_cnt, tbl[i].e_cnt);
            if (tbl[i].cx) chk($sformatf("v%0d_x_out", i), x_out, tbl[i].e_x);
        end
        $display("directed table: %0d vectors applied", tbl.size());

        // ---- randomized gapped tiles against a scoreboard ----
        cnt0 = tile_cnt;
        for (int t = 0; t < 3; t++) begin
            logic [DW-1:0] data [N];
            for (int i = 0; i < N; i++) data[i] = DW'($urandom);
            exp_tile = '0;
            for (int i = 0; i < N; i++) exp_tile[i*DW +: DW] = data[i];
            beat = 0;
            budget = 0;
            while (beat < N && budget < 200) begin
                in_valid = ($urandom_range(0, 1) == 1);
                in_data  = in_valid ? data[beat] : DW'($urandom);
                in_last  = (beat == N - 1);
                ln_done  = 1'b0;
                acc = in_valid && in_ready;
                @(posedge clk);
                #1;
                budget++;
                if (acc) beat++;
                if (beat < N) chk($sformatf("rnd%0d_no_early_start", t), ln_start, 1'b0);
            end
            if (beat < N) chk($sformatf("rnd%0d_fill_timeout", t), 1'b0, 1'b1);
            chk($sformatf("rnd%0d_ln_start", t), ln_start, 1'b1);
            chk($sformatf("rnd%0d_x_out", t), x_out, exp_tile);
            chk($sformatf("rnd%0d_frame_err", t), frame_err, 1'b0);
            repeat ($urandom_range(1, 5)) step(1'b1, DW'($urandom), 1'b0, 1'b0);
            chk($sformatf("rnd%0d_busy", t), busy, 1'b1);
            step(1'b0, '0, 1'b0, 1'b1);
            chk($sformatf("rnd%0d_ready_after_done", t), in_ready, 1'b1);
            chk($sformatf("rnd%0d_x_hold", t), x_out, exp_tile);
            $display("random tile %0d issued, tile_cnt=%0d", t, tile_cnt);
        end
        chk("rnd_tile_cnt", tile_cnt, cnt0 + 16'd3);

        // ---- reset while waiting for done, with done pending ----
        send_tile(16'h0070);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("wait_busy_before_rst", busy, 1'b1);
        rst = 1'b1;
        step(1'b0, '0, 1'b0, 1'b1);
        chk_reset_vals("rst_wait");
        rst = 1'b0; ln_done = 1'b0;
        #1;
        chk("rst_wait_ready_release", in_ready, 1'b1);
        send_tile(16'h0040);
        chk("rst_wait_ln_start", ln_start, 1'b1);
        chk("rst_wait_x_out", x_out, ramp(16'h0040));
        chk("rst_wait_tile_cnt", tile_cnt, 16'd1);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("rst_wait_reopen", in_ready, 1'b1);

        // ---- reset after beat 5 of a fill ----
        for (int i = 0; i < 5; i++) step(1'b1, DW'(16'h0050 + i), 1'b0, 1'b0);
        rst = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);
        chk_reset_vals("rst_fill");
        rst = 1'b0;
        #1;
        send_tile(16'h0060);
        chk("rst_fill_ln_start", ln_start, 1'b1);
        chk("rst_fill_x_out", x_out, ramp(16'h0060));
        chk("rst_fill_frame_err", frame_err, 1'b0);
        chk("rst_fill_tile_cnt", tile_cnt, 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ln_tile_packer.md
# ln_tile_packer

Streaming-to-tile packer on the input side of the layer-norm block. It accepts one `DATA_WIDTH` element per beat over a valid/ready stream, in row-major order. It assembles a full `SEQ_LEN`×`EMB_DIM` tile into the flattened bus the normaliser consumes, then issues a one-cycle start pulse. It holds the tile stable until the normaliser reports done, then reopens the stream for the next tile.

## Interface
Parameters:
- `DATA_WIDTH`, 16, element width (two's complement; not interpreted by this block).
- `SEQ_LEN`, 16, rows per tile.
- `EMB_DIM`, 32, elements per row.
- `SEQ_LEN*EMB_DIM` must be ≥ 2.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  stream beat valid.
- `in_data`  in  `DATA_WIDTH`  element value.
- `in_last`  in  1  marks final element of a tile.
- `in_ready`  out  1  packer can accept a beat.
- `x_out`  out  `DATA_WIDTH*SEQ_LEN*EMB_DIM`  flattened tile; element k at bits [k*DATA_WIDTH +: DATA_WIDTH], k = row*EMB_DIM+col.
- `ln_start`  out  1  one-cycle start pulse to the normaliser.
- `ln_done`  in  1  normaliser completion pulse.
- `busy`  out  1  tile issued, waiting for `ln_done`.
- `frame_err`  out  1  one-cycle framing error pulse.
- `tile_cnt`  out  16  tiles issued, wraps 0xFFFF→0.

## Operation
- A beat is accepted when `in_valid && in_ready`.
- Element index counter `k` is `$clog2(SEQ_LEN*EMB_DIM)` bits wide and resets to 0.
- States:
  - S_FILL:
    - `in_ready`=1.
    - An accepted beat writes `in_data` into slot k. All other slots hold their value.
    - If k == N-1 (N = `SEQ_LEN*EMB_DIM`): k→0, go to S_START. If `in_last`=0 on this beat, pulse `frame_err` and still issue the tile.
    - Else if `in_last`=1 (early last): pulse `frame_err`, k→0, stay in S_FILL. The partial tile is dropped. Slots already written are not cleared and are overwritten by the next tile.
    - Else k→k+1.
  - S_START: `ln_start`=1 for exactly this cycle, `tile_cnt`+1, go to S_WAIT. `in_ready`=0.
  - S_WAIT: `busy`=1, `in_ready`=0. On `ln_done`=1, go to S_FILL.
- `ln_done` is ignored outside S_WAIT.
- `x_out` is never modified in S_START or S_WAIT.
- `in_data` is opaque: no sign extension, saturation, or arithmetic.

## Timing
- Reset, held while `rst`=1:
  - State S_FILL, k=0.
  - `x_out`=0, `ln_start`=0, `busy`=0, `frame_err`=0, `tile_cnt`=0.
  - `in_ready`=0 (`in_ready` = state==S_FILL && !rst).
- First beat can be accepted in the first cycle with `rst`=0.
- Final beat accepted on edge T: `x_out` holds the full tile and `ln_start`=1 during cycle T+1. `busy`=1 from T+2.
- `ln_done` sampled high on edge D (in S_WAIT): `busy`=0 and `in_ready`=1 in cycle D+1.
- Minimum tile period: N + 2 cycles plus normaliser latency.
- `frame_err` is registered and high for the cycle after the offending beat.
- `ln_start`, `busy`, `tile_cnt` and `frame_err` are registered; `in_ready` is combinational from state and `rst`.
- Reset mid-operation (any state, including S_WAIT) returns to the reset values on the next edge. A pending `ln_done` is forgotten.
- Backpressure and gaps: `in_valid`=0 cycles leave k and `x_out` unchanged.

## Test plan
Scenarios use `SEQ_LEN`=2, `EMB_DIM`=4, N=8.
- Reset then 8 back-to-back beats 0x0001..0x0008, `in_last` on beat 8. Required:
  - `x_out` = 0x0008_0007_…_0001 (MSB to LSB).
  - `ln_start` high exactly 1 cycle after beat 8, `tile_cnt`=1, `frame_err` never high.
- Hold `ln_done`=0 for 20 cycles after start, driving `in_valid`=1 with 0xFFFF. Required: `in_ready`=0, `busy`=1, `x_out` unchanged. Then pulse `ln_done`: `in_ready`=1 next cycle.
- Early last: `in_last` on beat 3. Required: `frame_err` pulse, no `ln_start`. The next 8 beats 0x0010..0x0017 yield tile 0x0017..0x0010 in slots 7..0.
- Missing last: 8 beats with `in_last`=0. Required: `frame_err` pulse in the same cycle as `ln_start`, tile issued normally.
- Random `in_valid` gaps (≈50%) over 3 tiles with random data. Required: `x_out` matches the scoreboard at each `ln_start`, `tile_cnt`=3.
- Assert `rst` in S_WAIT and also after beat 5 of a fill. Required:
  - All outputs return to their reset values.
  - The next 8 beats form a clean tile starting at slot 0.
